// File: rtl/uart_frame_sched.sv
// rtl/uart_frame_sched.sv - round-robin packet scheduler framing measurement/status words for a byte UART
// Holds one pending word per source and streams header+type+payload+checksum through the busy handshake.
module uart_frame_sched #(
    parameter logic [7:0]  HDR0      = 8'hAA,
    parameter logic [7:0]  HDR1      = 8'h55,
    parameter logic [7:0]  TYPE_SUM  = 8'h01,
    parameter logic [7:0]  TYPE_STAT = 8'h02,
    parameter int unsigned BUSY_TO   = 4
) (
    input  logic        clk_40M,
    input  logic        rst_n,
    input  logic [31:0] sum_in,
    input  logic        sum_valid,
    input  logic [15:0] stat_in,
    input  logic        stat_valid,
    input  logic        busy,
    input  logic        clr_ovr,
    output logic [7:0]  txd_out,
    output logic        uart_en,
    output logic        pkt_active,
    output logic        overrun_sum,
    output logic        overrun_stat
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

    localparam logic [3:0] TO_LAST = 4'(BUSY_TO - 1);

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [31:0] frame_q;
    logic        is_stat_q;
    logic [7:0]  txd_q;
    logic        en_q;
    logic        act_q;
    logic        last_stat_q;

    logic [31:0] sum_hold_q, sum_hold_d;
    logic        sum_pend_q, sum_pend_d;
    logic [15:0] stat_hold_q, stat_hold_d;
    logic        stat_pend_q, stat_pend_d;
    logic        ovr_sum_q, ovr_sum_d;
    logic        ovr_stat_q, ovr_stat_d;

    logic        grant_sum;
    logic        grant_stat;
    logic [2:0]  last_idx;

    function automatic logic [7:0] frame_byte(input logic stat, input logic [31:0] f,
                                              input logic [2:0] i);
        logic [7:0] chk;
        logic [7:0] b;
        chk = stat ? (TYPE_STAT + f[15:8] + f[7:0])
                   : (TYPE_SUM + f[31:24] + f[23:16] + f[15:8] + f[7:0]);
        b = HDR0;
        case (i)
            3'd0: b = HDR0;
            3'd1: b = HDR1;
            3'd2: b = stat ? TYPE_STAT : TYPE_SUM;
            3'd3: b = stat ? f[15:8] : f[31:24];
            3'd4: b = stat ? f[7:0]  : f[23:16];
            3'd5: b = stat ? chk     : f[15:8];
            3'd6: b = f[7:0];
            3'd7: b = chk;
            default: b = HDR0;
        endcase
        return b;
    endfunction

    // Tie goes to the source that was not served last.
    assign grant_sum  = (state_q == S_IDLE) && sum_pend_q && (!stat_pend_q || last_stat_q);
    assign grant_stat = (state_q == S_IDLE) && stat_pend_q && !grant_sum;
    assign last_idx   = is_stat_q ? 3'd5 : 3'd7;

    always_comb begin
        sum_hold_d  = sum_hold_q;
        sum_pend_d  = sum_pend_q && !grant_sum;
        stat_hold_d = stat_hold_q;
        stat_pend_d = stat_pend_q && !grant_stat;
        // A slot freed by this cycle's grant can take the new word without overrun.
        if (sum_valid && (!sum_pend_q || grant_sum)) begin
            sum_hold_d = sum_in;
            sum_pend_d = 1'b1;
        end
        if (stat_valid && (!stat_pend_q || grant_stat)) begin
            stat_hold_d = stat_in;
            stat_pend_d = 1'b1;
        end
        ovr_sum_d  = (ovr_sum_q && !clr_ovr) || (sum_valid && sum_pend_q && !grant_sum);
        ovr_stat_d = (ovr_stat_q && !clr_ovr) || (stat_valid && stat_pend_q && !grant_stat);
    end

    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            sum_hold_q  <= '0;
            sum_pend_q  <= 1'b0;
            stat_hold_q <= '0;
            stat_pend_q <= 1'b0;
            ovr_sum_q   <= 1'b0;
            ovr_stat_q  <= 1'b0;
        end else begin
            sum_hold_q  <= sum_hold_d;
            sum_pend_q  <= sum_pend_d;
            stat_hold_q <= stat_hold_d;
            stat_pend_q <= stat_pend_d;
            ovr_sum_q   <= ovr_sum_d;
            ovr_stat_q  <= ovr_stat_d;
        end
    end

    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            frame_q     <= '0;
            is_stat_q   <= 1'b0;
            txd_q       <= '0;
            en_q        <= 1'b0;
            act_q       <= 1'b0;
            last_stat_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_q <= 1'b0;
                    if (grant_sum || grant_stat) begin
                        frame_q     <= grant_sum ? sum_hold_q : {16'h0000, stat_hold_q};
                        is_stat_q   <= grant_stat;
                        last_stat_q <= grant_stat;
                        idx_q       <= '0;
                        txd_q       <= HDR0;
                        en_q        <= 1'b1;
                        act_q       <= 1'b1;
                        state_q     <= S_SEND;
                    end
                end
                S_SEND: begin
                    en_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (busy || cnt_q == TO_LAST) begin
                        state_q <= S_WAIT_LO;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_WAIT_LO: begin
                    if (!busy) begin
                        if (idx_q == last_idx) begin
                            act_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            txd_q   <= frame_byte(is_stat_q, frame_q, idx_q + 3'd1);
                            en_q    <= 1'b1;
                            state_q <= S_SEND;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign txd_out      = txd_q;
    assign uart_en      = en_q;
    assign pkt_active   = act_q;
    assign overrun_sum  = ovr_sum_q;
    assign overrun_stat = ovr_stat_q;

endmodule
